// File: rtl/ring_position_ctrl.sv
// Shortest-path sequencer for a modulo-N position ring: accepts one target at a time
// and walks pos one step every STEP_DIV cycles in the shorter direction.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// MOVE  | stepping toward the target, one step per STEP_DIV unheld cycles
// DONE  | target reached, done pulses for one cycle
module ring_position_ctrl #(
    parameter int N        = 5,
    parameter int W        = 3,
    parameter int STEP_DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    input  logic [W-1:0] cmd_target,
    output logic         cmd_ready,
    input  logic         hold,
    output logic [W-1:0] pos,
    output logic         dir,
    output logic         step,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [W-1:0]  LAST   = W'(N - 1);
    localparam logic [W:0]    N_EXT  = (W + 1)'(N);
    localparam logic [DW-1:0] RELOAD = DW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    state_t        state_r, state_nx;
    logic [W-1:0]  pos_r, pos_nx;
    logic          dir_r, dir_nx;
    logic [W-1:0]  rem_r, rem_nx;
    logic [DW-1:0] div_r, div_nx;
    logic          step_r, step_nx;
    logic          err_r, err_nx;

    logic [W:0]    sum_up;
    logic [W:0]    dist_up;
    logic [W:0]    dist_dn;
    logic          target_ok;
    logic          go_up;

    // target + N - pos lies in 1..2N-1 for legal targets, so one conditional subtract wraps it
    always_comb begin
        sum_up    = {1'b0, cmd_target} + N_EXT - {1'b0, pos_r};
        dist_up   = (sum_up >= N_EXT) ? (sum_up - N_EXT) : sum_up;
        dist_dn   = N_EXT - dist_up;
        target_ok = ({1'b0, cmd_target} < N_EXT);
        go_up     = (dist_up <= dist_dn);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            pos_r   <= '0;
            dir_r   <= 1'b1;
            rem_r   <= '0;
            div_r   <= '0;
            step_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            pos_r   <= pos_nx;
            dir_r   <= dir_nx;
            rem_r   <= rem_nx;
            div_r   <= div_nx;
            step_r  <= step_nx;
            err_r   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        pos_nx   = pos_r;
        dir_nx   = dir_r;
        rem_nx   = rem_r;
        div_nx   = div_r;
        step_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (!target_ok) begin
                        err_nx = 1'b1;
                    end else if (dist_up == '0) begin
                        state_nx = DONE;
                    end else begin
                        dir_nx   = go_up;
                        rem_nx   = go_up ? dist_up[W-1:0] : dist_dn[W-1:0];
                        div_nx   = RELOAD;
                        state_nx = MOVE;
                    end
                end
            end
            MOVE: begin
                if (!hold) begin
                    if (div_r != '0) begin
                        div_nx = div_r - 1'b1;
                    end else begin
                        if (dir_r)
                            pos_nx = (pos_r == LAST) ? '0 : pos_r + 1'b1;
                        else
                            pos_nx = (pos_r == '0) ? LAST : pos_r - 1'b1;
                        step_nx = 1'b1;
                        rem_nx  = rem_r - 1'b1;
                        div_nx  = RELOAD;
                        if (rem_r == W'(1))
                            state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r == MOVE) || (state_r == DONE);
    assign done      = (state_r == DONE);
    assign pos       = pos_r;
    assign dir       = dir_r;
    assign step      = step_r;
    assign err       = err_r;

endmodule

// File: doc/ring_position_ctrl.md
Name: ring_position_ctrl

Overview:
- Command-driven sequencer for a modulo-N up/down position counter. This is the controller that picks the direction and the number of steps for the gray-code style counter datapath.
- Accepts a target position through a valid/ready handshake. It always moves along the shortest path around the ring, one step every STEP_DIV cycles.
- Exposes the live position, the direction and per-step strobes, and pulses done when the target is reached.
- Sits between the command source (test controller or host FSM) and any logic that consumes the position.

Parameters:
- N, 5, number of ring positions (0..N-1); N >= 2.
- W, 3, width of position and target; 2^W >= N.
- STEP_DIV, 1, clock cycles per step; >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_target  in  W  requested position.
- cmd_ready  out  1  controller can accept a command; high iff state is IDLE.
- hold  in  1  pauses stepping while high in MOVE.
- pos  out  W  current position (registered).
- dir  out  1  1 = up/increment, 0 = down/decrement (registered).
- step  out  1  one-cycle strobe; high in the cycle after pos changed.
- busy  out  1  high in MOVE or DONE.
- done  out  1  one-cycle pulse; high while state is DONE.
- err  out  1  one-cycle pulse; out-of-range target was consumed.

Behaviour:
- Reset (reset=0, asynchronous) sets: state=IDLE, pos=0, dir=1, step=0, done=0, err=0, remaining=0, divider=0. Therefore cmd_ready=1 and busy=0.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. Only one command is in flight at a time. cmd_ready is 0 in MOVE and DONE.
- Acceptance in IDLE, with u = (cmd_target - pos) mod N and d = N - u:
  - cmd_target >= N: err=1 for the next cycle; state stays IDLE; pos and dir are unchanged.
  - cmd_target == pos: go to DONE; no steps; dir is unchanged.
  - otherwise: dir = (u <= d) ? 1 : 0, so a tie goes up. remaining = min(u, d). divider = STEP_DIV-1. Go to MOVE.
- MOVE:
  - If hold=1, divider, pos and remaining are frozen.
  - Else if divider != 0, divider decrements.
  - Else: pos steps by ±1 per dir, with wrap (N-1 -> 0 going up, 0 -> N-1 going down). step=1 next cycle. remaining decrements. divider reloads to STEP_DIV-1.
  - When the step makes remaining reach 0, go to DONE on the same edge.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Timing for a command accepted at edge k with distance m (hold low):
  - pos updates at edges k+STEP_DIV, k+2*STEP_DIV, ..., k+m*STEP_DIV.
  - done is high from edge k+m*STEP_DIV to the next edge.
  - cmd_ready returns at k+m*STEP_DIV+1.
  - For m=0, done is high in the cycle right after edge k.
- dir is constant for the whole move and holds its last value in IDLE.
- Width rules: modular arithmetic uses a W+1 bit intermediate. pos is never >= N.
- Reset mid-move: immediate return to reset values; no done pulse; the command is dropped.
- cmd_valid while busy: ignored (not accepted). The source must keep it asserted until ready.
- hold asserted in IDLE or DONE: no effect.

Test Plan:
- Reset: assert reset=0 for 2 cycles, release -> pos=0, dir=1, cmd_ready=1, busy=0, done=0, step=0.
- N=5, STEP_DIV=1, pos=0, command target 2 -> dir=1; pos 1 then 2 on consecutive edges; two step pulses; done one cycle after pos=2; cmd_ready high on the following cycle.
- Wrap-down: pos=0, target 3 (u=3, d=2) -> dir=0; pos 4 then 3; done pulse. Then target 1 (u=3, d=2) -> dir=0; pos 2 then 1.
- Zero and invalid: pos=3, target 3 -> done one cycle after acceptance, no step, dir unchanged. Target 6 -> err one cycle, pos=3, state IDLE, no done.
- STEP_DIV=3, pos=0, target 1 -> pos changes exactly 3 cycles after acceptance. Asserting hold for 4 cycles mid-count delays the step by exactly 4 cycles.
- Tie and reset mid-move:
  - N=4, pos=0, target 2 -> dir=1; pos 1, 2.
  - N=5, target 2 from 0, then reset=0 after the first step -> pos=0 asynchronously; done never pulses; cmd_ready=1 after release.
